frequency_ascii_formatter: RTL and testbench
============================================

# frequency_ascii_formatter

Converts each 32-bit result from the frequency counter into a fixed-width, right-justified decimal ASCII line and streams it one byte at a time to a UART transmitter over a valid/ready handshake. It sits directly downstream of the frequency counter in the reference-clock domain, consuming its frequency word and one-cycle valid strobe. It replaces per-design ad-hoc formatting in the frequency-counter UART test designs.

## Interface

- LEADING_SPACES, 1, 1: suppressed leading zeros are emitted as 0x20; 0: zero-padded
- APPEND_CRLF, 1, 1: append 0x0D 0x0A after the digits (12-byte message); 0: 10-byte message
- clock  input  1  clock; same domain as the frequency counter's valid output
- reset_n  input  1  asynchronous, active-low reset
- frequency  input  32  unsigned binary value; sampled only when frequency_valid is high
- frequency_valid  input  1  one-cycle strobe: new value present
- data  output  8  ASCII byte
- data_valid  output  1  data holds a byte to be taken
- data_ready  input  1  UART transmitter accepts data this cycle
- busy  output  1  high in CONVERT or EMIT
- overrun_count  output  8  saturating count of values discarded by overwrite

## Operation

- Reset (asynchronous, reset_n low): state IDLE; data=0, data_valid=0, busy=0, overrun_count=0; pending slot empty; BCD register cleared.
- States: IDLE, CONVERT, EMIT.
- IDLE: frequency_valid high → latch frequency into shift register, clear 40-bit BCD register (10 digits), iteration counter=0, go to CONVERT.
- CONVERT: one double-dabble iteration per cycle (add 3 to every BCD digit >=5, then shift left by one with the binary MSB entering the BCD LSB); 32 iterations exactly; after the 32nd, go to EMIT with byte index 0.
- EMIT: bytes in order: digit 9 (most significant) … digit 0, then CR, LF if APPEND_CRLF.
  - Digit byte = 0x30 + digit.
  - LEADING_SPACES=1: each digit above digit 0 that is zero and has only zeros above it → 0x20. Digit 0 is always numeric.
- Byte advances only on a cycle with data_valid && data_ready. After the last byte transfers: pending slot full → load it, empty the slot, go to CONVERT; otherwise go to IDLE.
- Pending slot (one entry): frequency_valid in CONVERT or EMIT writes frequency into it.
  - If the slot is already full, the old value is overwritten and overrun_count increments, saturating at 255.
  - Values are never queued deeper than one.
- frequency_valid on the same cycle as the final byte transfer: value goes to the slot (counted as overrun if the slot was full), then is immediately consumed by the transition to CONVERT.

## Timing

- frequency_valid high at edge t in IDLE → busy=1 from t+1; CONVERT occupies t+1..t+32; data_valid=1 with the first byte from t+33.
- With data_ready held high, one byte transfers per cycle: a 12-byte message completes on edge t+44. busy=0 from t+45 if nothing is pending.
- Back-to-back from pending: the cycle after the final transfer is CONVERT iteration 1. data_valid is low for 32 cycles, then the next message starts.
- data_valid and data are registered outputs. While data_valid && !data_ready, data stays stable and data_valid stays high; data_valid never drops without a transfer except on reset.
- data_valid is 0 in IDLE and CONVERT.
- reset_n asserted mid-message: outputs clear immediately. The partial message is abandoned and the pending value lost. After release the block waits in IDLE for the next strobe.
- overrun_count is not cleared except by reset.

## Test plan

- frequency=4294967295, ready always high → bytes "4294967295\r\n" (34 32 39 34 39 36 37 32 39 35 0D 0A); first data_valid at t+33, busy low at t+45.
- frequency=0, LEADING_SPACES=1 → nine 0x20 then 0x30 0x0D 0x0A.
- frequency=1000 with LEADING_SPACES=0, APPEND_CRLF=0 → "0000001000", exactly 10 bytes, no CR/LF.
- frequency=250000000, data_ready toggled pseudo-randomly (≥30% low) → data stable while stalled; received string "250000000\r\n" preceded by one space; no byte duplicated or skipped.
- Strobes A=100 (IDLE), B=200 during CONVERT, C=300 during EMIT → output lines for 100 then 300 only; overrun_count=1; 32 cycles of data_valid=0 between the lines.
- reset_n pulsed low after 5 bytes of a message → data_valid, busy, overrun_count=0 asynchronously. A subsequent strobe of 7 yields a complete "         7\r\n".

Source files
------------

// File: rtl/frequency_ascii_formatter.sv
// -----------------------------------------------------------------------------
// frequency_ascii_formatter
//
// Turns each 32-bit frequency word into a fixed-width, right-justified decimal
// ASCII line (10 digits, optional CR LF) and streams it byte by byte over a
// valid/ready handshake to a UART transmitter. Binary-to-BCD conversion is a
// 32-cycle sequential double-dabble. One extra value may wait in a pending
// slot while a line is being converted or emitted; further values overwrite it
// and are counted in a saturating overrun counter.
//
// Parameters:
//   LEADING_SPACES  1: suppressed leading zeros are sent as 0x20; 0: zero-padded
//   APPEND_CRLF     1: 0x0D 0x0A follow the digits (12 bytes); 0: 10 bytes
// Ports:
//   clock            clock, same domain as the frequency counter
//   reset_n          asynchronous active-low reset
//   frequency        unsigned value, sampled when frequency_valid is high
//   frequency_valid  one-cycle strobe: new value present
//   data             ASCII byte (registered)
//   data_valid       data holds a byte to be taken (registered)
//   data_ready       downstream accepts data this cycle
//   busy             high while converting or emitting
//   overrun_count    saturating count of values lost by overwrite
// -----------------------------------------------------------------------------
module frequency_ascii_formatter #(
    parameter int LEADING_SPACES = 1,
    parameter int APPEND_CRLF    = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] frequency,
    input  logic        frequency_valid,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic [7:0]  overrun_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = (APPEND_CRLF != 0) ? 4'd11 : 4'd9;

    // One double-dabble iteration: add 3 to each digit >= 5, then shift left
    // with the next binary bit entering the BCD LSB.
    function automatic logic [39:0] dabble_step(input logic [39:0] bcd,
                                                input logic        bit_in);
        logic [39:0] adj;
        adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return {adj[38:0], bit_in};
    endfunction

    // Byte at position idx of the line: idx 0..9 are digits 9..0, then CR, LF.
    // A digit is blanked when it and every digit above it are zero, except
    // digit 0 which always prints.
    function automatic logic [7:0] msg_byte(input logic [39:0] bcd,
                                            input logic [3:0]  idx);
        logic [3:0]  pos;
        logic [5:0]  lsb;
        logic [39:0] upper;
        logic [7:0]  b;
        pos   = 4'd9 - idx;
        lsb   = {pos, 2'b00};
        upper = bcd >> lsb;
        if (idx == 4'd10) begin
            b = 8'h0D;
        end else if (idx == 4'd11) begin
            b = 8'h0A;
        end else if (idx > 4'd9) begin
            b = 8'h00;
        end else if ((LEADING_SPACES != 0) && (pos != 4'd0) && (upper == 40'd0)) begin
            b = 8'h20;
        end else begin
            b = 8'h30 + {4'h0, upper[3:0]};
        end
        return b;
    endfunction

    state_t      state_q;
    logic [31:0] bin_q;
    logic [39:0] bcd_q;
    logic [4:0]  iter_q;
    logic [3:0]  idx_q;
    logic [31:0] pend_q;
    logic        pend_full_q;
    logic [7:0]  overrun_q;
    logic [7:0]  data_q;
    logic        data_valid_q;

    logic [39:0] bcd_d;
    logic        final_xfer_s;

    // Next BCD value and detection of the transfer of the last byte of a line.
    always_comb begin
        bcd_d        = dabble_step(bcd_q, bin_q[31]);
        final_xfer_s = 1'b0;
        if ((state_q == ST_EMIT) && data_valid_q && data_ready && (idx_q == LAST_IDX)) begin
            final_xfer_s = 1'b1;
        end else begin
            final_xfer_s = 1'b0;
        end
    end

    // Main FSM: conversion, byte emission, pending slot and overrun counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bin_q        <= 32'd0;
            bcd_q        <= 40'd0;
            iter_q       <= 5'd0;
            idx_q        <= 4'd0;
            pend_q       <= 32'd0;
            pend_full_q  <= 1'b0;
            overrun_q    <= 8'd0;
            data_q       <= 8'd0;
            data_valid_q <= 1'b0;
        end else begin
            // Any strobe while busy lands in the slot; the final-transfer case
            // below consumes it in the same cycle (later assignment wins).
            if (frequency_valid && (state_q != ST_IDLE)) begin
                pend_q      <= frequency;
                pend_full_q <= 1'b1;
                if (pend_full_q && (overrun_q != 8'hFF)) begin
                    overrun_q <= overrun_q + 8'd1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (frequency_valid) begin
                        bin_q   <= frequency;
                        bcd_q   <= 40'd0;
                        iter_q  <= 5'd0;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q  <= bcd_d;
                    bin_q  <= {bin_q[30:0], 1'b0};
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == 5'd31) begin
                        // First byte comes straight from the final BCD value so
                        // data_valid rises on the same edge as the 32nd iteration.
                        state_q      <= ST_EMIT;
                        idx_q        <= 4'd0;
                        data_q       <= msg_byte(bcd_d, 4'd0);
                        data_valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (final_xfer_s) begin
                        data_valid_q <= 1'b0;
                        data_q       <= 8'd0;
                        if (pend_full_q || frequency_valid) begin
                            bin_q       <= frequency_valid ? frequency : pend_q;
                            bcd_q       <= 40'd0;
                            iter_q      <= 5'd0;
                            pend_full_q <= 1'b0;
                            state_q     <= ST_CONVERT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (data_valid_q && data_ready) begin
                        idx_q  <= idx_q + 4'd1;
                        data_q <= msg_byte(bcd_q, idx_q + 4'd1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    data_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_frequency_ascii_formatter.sv
module tb_frequency_ascii_formatter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] freq1, freq2;
    logic        fv1, fv2;
    logic [7:0]  data1, data2, ov1, ov2;
    logic        dv1, dv2, rdy1, rdy2, busy1, busy2;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    int          rx2 = 0;
    bit          rand_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    int          gap;

    always #5 clk = ~clk;

    frequency_ascii_formatter #(.LEADING_SPACES(1), .APPEND_CRLF(1)) dut (
        .clock(clk), .reset_n(reset_n), .frequency(freq1), .frequency_valid(fv1),
        .data(data1), .data_valid(dv1), .data_ready(rdy1), .busy(busy1),
        .overrun_count(ov1)
    );

    frequency_ascii_formatter #(.LEADING_SPACES(0), .APPEND_CRLF(0)) dut2 (
        .clock(clk), .reset_n(reset_n), .frequency(freq2), .frequency_valid(fv2),
        .data(data2), .data_valid(dv2), .data_ready(rdy2), .busy(busy2),
        .overrun_count(ov2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_line(input bit which, input string s, input bit crlf);
        for (int i = 0; i < s.len(); i++) begin
            if (which) q2.push_back(s[i]); else q1.push_back(s[i]);
        end
        if (crlf) begin
            if (which) begin q2.push_back(8'h0D); q2.push_back(8'h0A); end
            else begin q1.push_back(8'h0D); q1.push_back(8'h0A); end
        end
    endtask

    // strobe: value sampled on edge t; returns 1 ns after edge t
    task automatic strobe(input bit which, input logic [31:0] v);
        @(posedge clk); #1;
        if (which) begin freq2 = v; fv2 = 1'b1; end else begin freq1 = v; fv1 = 1'b1; end
        @(posedge clk); #1;
        fv1 = 1'b0; fv2 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk); #1;
            if (which) done = !busy2 && (q2.size() == 0);
            else       done = !busy1 && (q1.size() == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: timeout, busy1=%0b q1=%0d busy2=%0b q2=%0d required idle and empty",
                     name, busy1, q1.size(), busy2, q2.size());
        end
    endtask

    // ready driver for instance 1 (pseudo-random ~40% low when enabled)
    initial begin
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        forever begin
            @(posedge clk); #1;
            rdy1 = rand_en ? ($urandom_range(9, 0) >= 4) : 1'b1;
        end
    end

    // monitor / scoreboard for instance 1
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, dv1}, 32'd1);
                chk("stall_data", {24'd0, data1}, {24'd0, prev_data});
            end
            if (dv1 && rdy1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte1: got %0h expected no byte", data1);
                end else begin
                    chk("byte1", {24'd0, data1}, {24'd0, q1.pop_front()});
                end
            end
            prev_stall <= dv1 && !rdy1;
            prev_data  <= data1;
        end
    end

    // monitor / scoreboard for instance 2
    always @(negedge clk) begin
        if (reset_n && dv2 && rdy2) begin
            rx2 <= rx2 + 1;
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte2: got %0h expected no byte", data2);
            end else begin
                chk("byte2", {24'd0, data2}, {24'd0, q2.pop_front()});
            end
        end
    end

    initial begin
        bit seen;
        reset_n = 1'b0;
        freq1 = 32'd0; freq2 = 32'd0; fv1 = 1'b0; fv2 = 1'b0;
        #3;
        chk("rst_dv", {31'd0, dv1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_data", {24'd0, data1}, 32'd0);
        chk("rst_ovr", {24'd0, ov1}, 32'd0);
        #19 reset_n = 1'b1;

        // 1: max value, latency and busy timing
        push_line(1'b0, "4294967295", 1'b1);
        strobe(1'b0, 32'hFFFF_FFFF);
        chk("t1_busy_start", {31'd0, busy1}, 32'd1);
        chk("t1_dv_start", {31'd0, dv1}, 32'd0);
        repeat (31) @(posedge clk);
        #1 chk("t1_dv_before", {31'd0, dv1}, 32'd0);
        @(posedge clk);
        #1 chk("t1_dv_first", {31'd0, dv1}, 32'd1);
        chk("t1_first_byte", {24'd0, data1}, 32'h34);
        repeat (11) @(posedge clk);
        #1 chk("t1_busy_last", {31'd0, busy1}, 32'd1);
        @(posedge clk);
        #1 chk("t1_busy_end", {31'd0, busy1}, 32'd0);
        chk("t1_dv_end", {31'd0, dv1}, 32'd0);
        chk("t1_queue", q1.size(), 32'd0);

        // 2: zero with leading spaces
        push_line(1'b0, "         0", 1'b1);
        strobe(1'b0, 32'd0);
        wait_done(1'b0, "t2_done");

        // 3: zero-padded, no CRLF
        push_line(1'b1, "0000001000", 1'b0);
        strobe(1'b1, 32'd1000);
        wait_done(1'b1, "t3_done");
        repeat (3) @(posedge clk);
        #1 chk("t3_count", rx2, 32'd10);
        chk("t3_dv_after", {31'd0, dv2}, 32'd0);

        // 4: back-pressure
        rand_en = 1'b1;
        push_line(1'b0, " 250000000", 1'b1);
        strobe(1'b0, 32'd250000000);
        wait_done(1'b0, "t4_done");
        rand_en = 1'b0;
        chk("t4_ovr", {24'd0, ov1}, 32'd0);

        // 5: A in IDLE, B during CONVERT, C during EMIT
        push_line(1'b0, "       100", 1'b1);
        push_line(1'b0, "       300", 1'b1);
        strobe(1'b0, 32'd100);
        repeat (3) @(posedge clk);
        strobe(1'b0, 32'd200);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = dv1;
        end
        chk("t5_emit_seen", {31'd0, seen}, 32'd1);
        strobe(1'b0, 32'd300);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            seen = (q1.size() == 12);
        end
        chk("t5_line1_seen", {31'd0, seen}, 32'd1);
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dv1) break;
            gap++;
        end
        chk("t5_gap", gap, 32'd32);
        wait_done(1'b0, "t5_done");
        chk("t5_ovr", {24'd0, ov1}, 32'd1);

        // 6: reset mid-message, pending value lost
        push_line(1'b0, " 1234", 1'b0);
        strobe(1'b0, 32'd123456789);
        repeat (3) @(posedge clk);
        strobe(1'b0, 32'd99);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); #1;
            seen = (q1.size() == 0);
        end
        chk("t6_five_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("t6_rst_dv", {31'd0, dv1}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy1}, 32'd0);
        chk("t6_rst_ovr", {24'd0, ov1}, 32'd0);
        #1 reset_n = 1'b1;
        q1.delete();
        repeat (40) @(posedge clk);
        #1 chk("t6_pending_lost", {31'd0, busy1}, 32'd0);
        chk("t6_dv_idle", {31'd0, dv1}, 32'd0);
        push_line(1'b0, "         7", 1'b1);
        strobe(1'b0, 32'd7);
        wait_done(1'b0, "t6_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
